layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Sequences one fully connected neural-network layer built from NUM_NEURONS
// independent neuron blocks that share a broadcast input bus.
//
//   LOAD  : accept NUM_INPUTS activation words from the previous layer.
//   FEED  : replay the buffered vector to every neuron, one word per cycle,
//           with no gaps.
//   WAIT  : collect each neuron's single-cycle result as it arrives. Give up
//           after TIMEOUT cycles, raising a sticky err flag.
//   DRAIN : stream the NUM_NEURONS results to the next layer using a
//           valid/ready handshake. Pulse done after the last word.
//
// Ports
//   clk, rst      : clock; asynchronous active-high reset
//   in_data/valid : previous-layer activation stream (in_ready is back-pressure)
//   nrn_data/valid: broadcast to every neuron's myinput / myinputValid
//   nrn_out       : packed neuron results, neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//   nrn_outvalid  : per-neuron single-cycle result strobe
//   out_data/valid: result stream to the next layer (out_ready is back-pressure)
//   busy          : high in every state except LOAD
//   done          : one-cycle pulse after the last result word is accepted
//   err           : sticky WAIT-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module layer_sequencer #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             nrn_data,
  output logic                              nrn_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]            nrn_outvalid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  // Buffer address, FEED counter (must reach NUM_INPUTS), result index, and
  // WAIT counter (must reach TIMEOUT).
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int FW = $clog2(NUM_INPUTS + 1);
  localparam int RW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, FEED, WAIT, DRAIN} state_t;

  state_t                 state;
  logic [IW-1:0]          wr_idx;
  logic [FW-1:0]          feed_idx;
  logic [RW-1:0]          rd_idx;
  logic [RW-1:0]          rd_next;
  logic [CW-1:0]          wait_cnt;
  logic [NUM_NEURONS-1:0] flags;
  logic [NUM_NEURONS-1:0] flags_d;

  logic [DATA_WIDTH-1:0]  in_buf [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]  cap    [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  cap_d  [NUM_NEURONS];

  logic load_accept;
  logic load_last;
  logic wait_done;
  logic wait_expired;

  // ---------------------------------------------------------------------------
  // Next-value logic for the capture flags and capture register file.
  // Both are cleared on the LOAD->FEED edge. Results are merged only while in
  // WAIT, so several neurons can land in the same cycle. A repeated strobe for
  // a neuron simply overwrites its earlier value.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    flags_d = flags;
    cap_d   = cap;
    load_accept = (state == LOAD) && in_valid;
    load_last   = load_accept && (wr_idx == IW'(NUM_INPUTS - 1));

    if (load_last) begin
      flags_d = '0;
      for (int i = 0; i < NUM_NEURONS; i++) cap_d[i] = '0;
    end else if (state == WAIT) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (nrn_outvalid[i]) begin
          flags_d[i] = 1'b1;
          cap_d[i]   = nrn_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    // wait_done includes flags set in this same cycle.
    wait_done    = (state == WAIT) && (&flags_d);
    wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
    rd_next      = rd_idx + 1'b1;
  end

  // NOTE: the input buffer and capture file are storage, not control state.
  // They have no reset, so they map onto plain RAM/flops without reset
  // routing. Every read is of a word written (or cleared) earlier in the
  // current pass.
  always_ff @(posedge clk) begin
    if (load_accept) in_buf[wr_idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    cap <= cap_d;
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      wr_idx    <= '0;
      feed_idx  <= '0;
      rd_idx    <= '0;
      wait_cnt  <= '0;
      flags     <= '0;
      in_ready  <= 1'b1;
      nrn_data  <= '0;
      nrn_valid <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done  <= 1'b0;
      flags <= flags_d;

      unique case (state)
        LOAD: begin
          if (load_accept) begin
            if (load_last) begin
              wr_idx   <= '0;
              feed_idx <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= FEED;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end

        FEED: begin
          if (feed_idx == FW'(NUM_INPUTS)) begin
            nrn_valid <= 1'b0;
            nrn_data  <= '0;
            wait_cnt  <= '0;
            state     <= WAIT;
          end else begin
            nrn_valid <= 1'b1;
            nrn_data  <= in_buf[feed_idx[IW-1:0]];
            feed_idx  <= feed_idx + 1'b1;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // The first result word is loaded from cap_d so that results arriving
          // on the final WAIT cycle are included.
          if (wait_done) begin
            rd_idx    <= '0;
            out_valid <= 1'b1;
            out_data  <= cap_d[0];
            state     <= DRAIN;
          end else if (wait_expired) begin
            // Missing neurons read back as the zero cleared on FEED entry.
            err       <= 1'b1;
            rd_idx    <= '0;
            out_valid <= 1'b1;
            out_data  <= cap_d[0];
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == RW'(NUM_NEURONS - 1)) begin
              rd_idx    <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              rd_idx   <= rd_next;
              out_data <= cap[rd_next];
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
`timescale 1ns/1ps

module tb_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    nrn_data;
  logic             nrn_valid;
  logic [NN*DW-1:0] nrn_out;
  logic [NN-1:0]    nrn_outvalid;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  layer_sequencer #(
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .nrn_data    (nrn_data),
    .nrn_valid   (nrn_valid),
    .nrn_out     (nrn_out),
    .nrn_outvalid(nrn_outvalid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  // Expects NI gap-free broadcast words, then nrn_valid low (WAIT entered).
  task automatic feed_check(input string tag, input logic [DW-1:0] e0, e1, e2, e3);
    logic [DW-1:0] exp_w [NI];
    int n;
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    n = 0;
    while (!nrn_valid && n < 3) begin
      tick();
      n++;
    end
    check({tag, "_start"}, {31'd0, nrn_valid}, 32'd1);
    for (int k = 0; k < NI; k++) begin
      check({tag, "_valid"}, {31'd0, nrn_valid}, 32'd1);
      check({tag, "_data"}, {16'd0, nrn_data}, {16'd0, exp_w[k]});
      tick();
    end
    check({tag, "_end"}, {31'd0, nrn_valid}, 32'd0);
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain_entry"}, {31'd0, out_valid}, 32'd1);
  endtask

  // Accepts every result word immediately and checks the done pulse.
  task automatic drain_all(input string tag, input logic [DW-1:0] e0, e1, e2);
    logic [DW-1:0] exp_w [NN];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2;
    out_ready = 1'b1;
    for (int k = 0; k < NN; k++) begin
      check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_od"}, {16'd0, out_data}, {16'd0, exp_w[k]});
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    in_data      = '0;
    in_valid     = 1'b0;
    nrn_out      = '0;
    nrn_outvalid = '0;
    out_ready    = 1'b0;
    #2;
    // Reset state.
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_nrn_valid", {31'd0, nrn_valid}, 32'd0);
    check("rst_nrn_data",  {16'd0, nrn_data},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Pass 1: back-to-back load, out-of-order results, stalled drain.
    for (int k = 1; k <= NI; k++) load_word(DW'(k));
    check("p1_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("p1_busy",         {31'd0, busy},     32'd1);
    feed_check("p1_feed", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    nrn_outvalid = 3'b100;
    nrn_out[2*DW +: DW] = 16'h00C0;
    tick();
    nrn_outvalid = 3'b011;
    nrn_out[0 +: DW]  = 16'h00A0;
    nrn_out[DW +: DW] = 16'h00B0;
    tick();
    nrn_outvalid = '0;
    check("p1_ov0", {31'd0, out_valid}, 32'd1);
    check("p1_od0", {16'd0, out_data},  32'h00A0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("p1_stall_ov", {31'd0, out_valid}, 32'd1);
      check("p1_stall_od", {16'd0, out_data},  32'h00B0);
    end
    out_ready = 1'b1;
    tick();
    check("p1_od2", {16'd0, out_data},  32'h00C0);
    check("p1_ov2", {31'd0, out_valid}, 32'd1);
    tick();
    out_ready = 1'b0;
    check("p1_ov_low",   {31'd0, out_valid}, 32'd0);
    check("p1_done",     {31'd0, done},      32'd1);
    check("p1_err",      {31'd0, err},       32'd0);
    check("p1_busy_low", {31'd0, busy},      32'd0);
    tick();
    check("p1_done_pulse", {31'd0, done}, 32'd0);

    // Pass 2: gapped load, strobes ignored outside WAIT, neuron 2 silent -> timeout.
    nrn_outvalid = 3'b100;
    nrn_out[2*DW +: DW] = 16'h0077;
    load_word(16'h0011); tick();
    load_word(16'h0022); tick();
    load_word(16'h0033); tick();
    load_word(16'h0044);
    feed_check("p2_feed", 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    nrn_outvalid = 3'b001;
    nrn_out[0 +: DW] = 16'h000A;
    tick();
    nrn_outvalid = 3'b011;
    nrn_out[0 +: DW]  = 16'h001A;
    nrn_out[DW +: DW] = 16'h001B;
    tick();
    nrn_outvalid = '0;
    check("p2_err_pending", {31'd0, err},       32'd0);
    check("p2_no_drain",    {31'd0, out_valid}, 32'd0);
    wait_out_valid("p2", 3 * TO);
    check("p2_err_set", {31'd0, err}, 32'd1);
    drain_all("p2", 16'h001A, 16'h001B, 16'h0000);
    check("p2_err_sticky", {31'd0, err}, 32'd1);

    // Pass 3: reset mid-FEED after two broadcast words.
    for (int k = 5; k <= 8; k++) load_word(DW'(k));
    tick();
    check("p3_w0", {16'd0, nrn_data}, 32'h0005);
    tick();
    check("p3_w1",  {16'd0, nrn_data}, 32'h0006);
    check("p3_err", {31'd0, err},      32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("p3_rst_nrn_valid", {31'd0, nrn_valid}, 32'd0);
    check("p3_rst_busy",      {31'd0, busy},      32'd0);
    check("p3_rst_err",       {31'd0, err},       32'd0);
    check("p3_rst_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("p3_in_ready", {31'd0, in_ready}, 32'd1);

    // Pass 4: partial load discarded by reset, then a clean pass with all
    // results arriving together.
    load_word(16'h00EE);
    load_word(16'h00EF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 1; k <= NI; k++) load_word(DW'(16'h0100 + k));
    feed_check("p4_feed", 16'h0101, 16'h0102, 16'h0103, 16'h0104);
    nrn_outvalid = 3'b111;
    nrn_out = {16'h0203, 16'h0202, 16'h0201};
    tick();
    nrn_outvalid = '0;
    drain_all("p4", 16'h0201, 16'h0202, 16'h0203);
    check("p4_err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
